seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//  Receive side of the 7-segment display interface. Samples a multiplexed, active-low
//  segment/anode bus (as driven by our hex display logic) and decodes each digit back to
//  its hex nibble. Assembles one nibble per digit position into a word.
//  Presents the word with a one-cycle valid strobe once every position has been captured.
//  Used as an on-chip display monitor and as a loop-back checker for display output.
// PARAMETERS
//  NUM_DIGITS     8   digit positions on the bus; data_out width = 4*NUM_DIGITS
//  STABLE_CYCLES  4   consecutive identical synchronized samples required to capture (>=1)
// PORTS
//  clk         in   1             system clock, rising edge
//  reset       in   1             asynchronous, active-high reset
//  seg_n       in   7             segments, active low; bit0=a .. bit6=g
//  an_n        in   NUM_DIGITS    digit enables, active low, one-hot-low when valid
//  data_out    out  4*NUM_DIGITS  last complete frame; nibble i = digit i
//  blank_mask  out  NUM_DIGITS    bit i set if digit i was blank (7'h7F) in that frame
//  data_valid  out  1             1-cycle pulse when data_out/blank_mask update
//  decode_err  out  1             1-cycle pulse on capture of an undecodable pattern
// BEHAVIOUR
//  - Reset (async, clk-independent): data_out=0, blank_mask=0, data_valid=0, decode_err=0,
//    sync regs=all-ones (idle bus), seen mask=0, shadow nibbles=0, FSM=IDLE, counter=0.
//  - Inputs pass through a 2-flop synchronizer; all logic below uses synchronized values.
//  - Select valid: exactly one bit of an_n low. Zero or multiple low -> FSM to IDLE, counter=0.
//  - Decode table, 7'b g..a: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08
//    B=03 C=46 D=21 E=06 F=0E; blank=7F. Any other pattern is invalid.
//  - FSM states: IDLE, SETTLE, HOLD.
//    IDLE   -> SETTLE when select valid; counter=1.
//    SETTLE -> if (an_n,seg_n) equals previous sample: counter++.
//              Otherwise counter=1 and stay in SETTLE, or go to IDLE if select invalid.
//              When counter reaches STABLE_CYCLES: capture edge, then go to HOLD.
//    HOLD   -> stay while sample is unchanged; no further captures.
//              Any change -> SETTLE with counter=1, or IDLE if select invalid.
//  - STABLE_CYCLES=1: capture on the first valid sample; SETTLE lasts 0 extra cycles.
//  - Counter width is $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.
//  - Capture edge for digit i:
//    decodable -> shadow[i]=nibble, seen[i]=1, blank shadow[i]=0;
//    blank     -> shadow[i]=0, blank shadow[i]=1, seen[i]=1;
//    invalid   -> decode_err pulses next cycle; shadow and seen unchanged.
//  - Re-capture of a digit already seen in the current frame overwrites its shadow. No error.
//  - Frame completion: when seen becomes all-ones, on the next edge:
//    data_out<=shadow, blank_mask<=blank shadow, data_valid=1 for exactly one cycle,
//    seen<=0. If a capture occurs on that same edge, it is applied to the new frame's seen mask.
//  - Latency: a bus change reaches the FSM 2 cycles later.
//    Capture lands STABLE_CYCLES-1 edges after the first FSM sample.
//    data_valid follows the completing capture by 1 cycle.
//  - data_out holds between frames. Partial frames are never exposed.
//  - Reset mid-frame discards shadow and seen. The first valid after reset requires all digits.
// STRUCTURE
//  - seg7_pkg holds:
//    SEG_* localparams (16 glyphs + SEG_BLANK);
//    typedef enum logic [1:0] {IDLE,SETTLE,HOLD} cap_state_t;
//    function seg7_decode returning {valid, blank, nibble}.
//    The display encoder shares the glyph constants.
//  - One sub-module: seg7_decode (combinational: seg_n -> nibble/valid/blank), unit-testable.
//  - The onehot check, FSM, counter, shadow regs and frame logic live in seg7_capture.
// TESTING (NUM_DIGITS=8, STABLE_CYCLES=4 unless noted)
//  - Scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 10 cycles
//    -> one data_valid pulse, data_out=32'h87654321, blank_mask=0.
//  - Glitch: hold seg_n=7'h40 for 3 cycles then 7'h79 for 6 on digit 0
//    -> digit 0 captured as 1, never 0.
//  - Invalid 7'h7E held 8 cycles on digit 3
//    -> one decode_err pulse; no data_valid until digit 3 is shown valid.
//  - an_n=8'hFC (two low) for 20 cycles -> no capture, no error.
//    Also run digit 5 blank (7'h7F) in a full scan -> nibble5=0, blank_mask=8'h20.
//  - Assert reset after 5 of 8 digits are captured, then scan all 8 showing A..F,0,1
//    -> data_valid fires only after all 8, data_out=32'h10FEDCBA.
//  - STABLE_CYCLES=1: scan each digit for 1 cycle
//    -> every digit captured, data_valid once per full scan.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants, capture FSM state type and the segment-to-nibble decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} cap_state_t;

  typedef struct packed {
    logic       valid;  // recognised glyph or blank
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg_n);
    seg7_dec_t d;
    d.valid  = 1'b1;
    d.blank  = 1'b0;
    d.nibble = 4'h0;
    case (seg_n)
      SEG_0:     d.nibble = 4'h0;
      SEG_1:     d.nibble = 4'h1;
      SEG_2:     d.nibble = 4'h2;
      SEG_3:     d.nibble = 4'h3;
      SEG_4:     d.nibble = 4'h4;
      SEG_5:     d.nibble = 4'h5;
      SEG_6:     d.nibble = 4'h6;
      SEG_7:     d.nibble = 4'h7;
      SEG_8:     d.nibble = 4'h8;
      SEG_9:     d.nibble = 4'h9;
      SEG_A:     d.nibble = 4'hA;
      SEG_B:     d.nibble = 4'hB;
      SEG_C:     d.nibble = 4'hC;
      SEG_D:     d.nibble = 4'hD;
      SEG_E:     d.nibble = 4'hE;
      SEG_F:     d.nibble = 4'hF;
      SEG_BLANK: d.blank  = 1'b1;
      default:   d.valid  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one active-low segment pattern into nibble/valid/blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       valid,
  output logic       blank
);

  seg7_dec_t dec;

  always_comb begin
    dec    = seg7_pkg::seg7_decode(seg_n);
    nibble = dec.nibble;
    valid  = dec.valid;
    blank  = dec.blank;
  end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed 7-segment bus, debounces each digit select and assembles a frame of
// nibbles, emitting a one-cycle valid strobe once every digit position has been captured.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] data_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    data_valid,
  output logic                    decode_err
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_p;
  logic [6:0]            seg_s1, seg_s2, seg_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1  <= '1;
      an_s2  <= '1;
      an_p   <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
    end else begin
      an_s1  <= an_n;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  logic [NUM_DIGITS-1:0] sel;
  logic                  sel_valid;
  logic                  same;

  assign sel       = ~an_s2;
  assign sel_valid = (sel != '0) && ((sel & (sel - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == '0);
  assign same      = (an_s2 == an_p) && (seg_s2 == seg_p);

  logic [3:0] dec_nibble;
  logic       dec_valid;
  logic       dec_blank;

  seg7_decode u_decode (
    .seg_n  (seg_s2),
    .nibble (dec_nibble),
    .valid  (dec_valid),
    .blank  (dec_blank)
  );

  cap_state_t    state_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          fire;

  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (!sel_valid) begin
      cnt_d = '0;
    end else if (!(state_q == HOLD && same)) begin
      // Any fresh sample restarts the count at 1; only an unchanged one in SETTLE extends it.
      cnt_d = (state_q == SETTLE && same) ? cnt_inc : CNT_ONE;
      fire  = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!sel_valid) begin
        state_q <= IDLE;
      end else if (fire) begin
        state_q <= HOLD;
      end else if (!(state_q == HOLD && same)) begin
        state_q <= SETTLE;
      end
    end
  end

  logic [NUM_DIGITS-1:0][3:0] shadow_q;
  logic [NUM_DIGITS-1:0]      blank_sh_q;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic                       frame_done;
  logic                       cap_ok;

  assign frame_done = &seen_q;
  assign cap_ok     = fire && dec_valid;

  // A capture on the completion edge belongs to the next frame.
  always_comb begin
    seen_d = frame_done ? '0 : seen_q;
    if (cap_ok) seen_d = seen_d | sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q   <= '0;
      blank_sh_q <= '0;
      seen_q     <= '0;
      data_out   <= '0;
      blank_mask <= '0;
      data_valid <= 1'b0;
      decode_err <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      data_valid <= frame_done;
      decode_err <= fire && !dec_valid;
      if (frame_done) begin
        data_out   <= shadow_q;
        blank_mask <= blank_sh_q;
      end
      if (cap_ok) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            shadow_q[i]   <= dec_blank ? 4'h0 : dec_nibble;
            blank_sh_q[i] <= dec_blank;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: directed digit scans with hand-computed frames.
module tb_seg7_capture;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  blank;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n, seg1_n;
  logic [7:0]  an_n, an1_n;
  logic [31:0] dout4, dout1;
  logic [7:0]  bm4, bm1;
  logic        dv4, dv1, err4, err1;

  frame_t q4[$];
  frame_t q1[$];
  int     err_pend = 0;
  int     vectors = 0;
  int     miscompares = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .data_out   (dout4),
    .blank_mask (bm4),
    .data_valid (dv4),
    .decode_err (err4)
  );

  seg7_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .seg_n      (seg1_n),
    .an_n       (an1_n),
    .data_out   (dout1),
    .blank_mask (bm1),
    .data_valid (dv1),
    .decode_err (err1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    frame_t f;
    if (dv4) begin
      if (q4.size() == 0) begin
        check("unexpected_valid_s4", 1, 0);
      end else begin
        f = q4.pop_front();
        check("frame_data_s4", dout4, f.data);
        check("frame_blank_s4", bm4, f.blank);
      end
    end
    if (err4) begin
      check("decode_err_expected", (err_pend > 0), 1);
      if (err_pend > 0) err_pend--;
    end
    if (dv1) begin
      if (q1.size() == 0) begin
        check("unexpected_valid_s1", 1, 0);
      end else begin
        f = q1.pop_front();
        check("frame_data_s1", dout1, f.data);
        check("frame_blank_s1", bm1, f.blank);
      end
    end
    if (err1) check("decode_err_s1", 1, 0);
  end

  task automatic show(input int d, input logic [6:0] s, input int n);
    logic [7:0] a;
    a    = '1;
    a[d] = 1'b0;
    an_n  = a;
    seg_n = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    an_n  = '1;
    seg_n = '1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show1(input int d, input logic [6:0] s);
    logic [7:0] a;
    a    = '1;
    a[d] = 1'b0;
    an1_n  = a;
    seg1_n = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    an_n   = '1;
    seg_n  = '1;
    an1_n  = '1;
    seg1_n = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", dout4, 32'h0);
    check("reset_blank_mask", bm4, 8'h0);
    check("reset_valid_err", {dv4, err4, dv1, err1}, 4'b0000);
    reset = 1'b0;
    idle(4);

    // Plain scan 1..8.
    q4.push_back(frame_t'{32'h87654321, 8'h00});
    for (int d = 0; d < 8; d++) show(d, glyph[d + 1], 10);
    idle(10);

    // Digit 0 last, with a short '0' glitch before a settled '1'.
    q4.push_back(frame_t'{32'hFEDCBA91, 8'h00});
    for (int d = 1; d < 8; d++) show(d, glyph[d + 8], 10);
    show(0, 7'h40, 3);
    show(0, 7'h79, 6);
    idle(10);

    // Undecodable pattern on digit 3 holds the frame open.
    err_pend++;
    q4.push_back(frame_t'{32'h76543210, 8'h00});
    show(3, 7'h7E, 8);
    for (int d = 0; d < 8; d++) if (d != 3) show(d, glyph[d], 10);
    idle(20);
    check("frame_held_for_digit3", q4.size(), 1);
    check("single_decode_err", err_pend, 0);
    show(3, glyph[3], 10);
    idle(10);

    // Two selects low must be ignored; then a scan with digit 5 blank.
    an_n  = 8'hFC;
    seg_n = glyph[9];
    repeat (20) @(posedge clk);
    #1;
    idle(5);
    q4.push_back(frame_t'{32'h76043210, 8'h20});
    for (int d = 0; d < 8; d++) show(d, (d == 5) ? 7'h7F : glyph[d], 10);
    idle(10);

    // Reset after a partial frame; the next frame must need all eight digits again.
    for (int d = 0; d < 5; d++) show(d, glyph[d + 2], 10);
    idle(5);
    #2 reset = 1'b1;
    #2;
    check("async_reset_data_out", dout4, 32'h0);
    check("async_reset_blank", bm4, 8'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    q4.push_back(frame_t'{32'h10FEDCBA, 8'h00});
    show(5, glyph[15], 10);
    show(6, glyph[0], 10);
    show(7, glyph[1], 10);
    idle(10);
    check("no_valid_after_partial", q4.size(), 1);
    for (int d = 0; d < 5; d++) show(d, glyph[10 + d], 10);
    idle(10);

    // STABLE_CYCLES=1: one cycle per digit, back-to-back frames.
    q1.push_back(frame_t'{32'hFEDCBA98, 8'h00});
    q1.push_back(frame_t'{32'h87654321, 8'h00});
    for (int d = 0; d < 8; d++) show1(d, glyph[8 + d]);
    for (int d = 0; d < 8; d++) show1(d, glyph[1 + d]);
    an1_n  = '1;
    seg1_n = '1;
    idle(10);

    check("s4_frames_all_seen", q4.size(), 0);
    check("s1_frames_all_seen", q1.size(), 0);
    check("decode_err_all_seen", err_pend, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
